wb_timer_bank: RTL and testbench

- Parametrised successor to the single wb_counter on Caravel's user Wishbone port.
- Provides NUM_CH independent down-counting timers, each COUNT_W bits wide, with per-channel auto-reload or one-shot mode, sticky hit flags and a combined interrupt.
- Instantiated in chip_core on the user Wishbone bus; irq_o drives user_irq_core.

---
 rtl/wb_timer_pkg.sv | 38 +++
 rtl/wb_timer_channel.sv | 100 ++++++++++
 rtl/wb_timer_bank.sv | 95 +++++++++
 tb/tb_wb_timer_bank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the wb_timer_bank Wishbone timer block: register offsets,
// CTRL layout and small helpers used by both the top and the per-channel logic.
package wb_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PSC_LSB = 8;

    typedef struct packed {
        logic [7:0] psc;
        logic       ie;
        logic       auto_rl;
        logic       en;
    } ctrl_t;

    // Byte-lane merge: lanes with sel set take the new data, others keep the old value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        return {16'h0000, c.psc, 5'b00000, c.ie, c.auto_rl, c.en};
    endfunction

endpackage

// File: rtl/wb_timer_channel.sv
// One down-counting timer channel with auto-reload/one-shot modes and a sticky HIT flag.
// Optional per-channel prescaler enabled by defining WB_TIMER_PRESCALER_EN.
module wb_timer_channel
    import wb_timer_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_ctrl,
    input  logic               wr_count,
    input  logic               wr_reload,
    input  logic               wr_status,
    input  logic [31:0]        wdata,
    input  logic [3:0]         sel,
    output ctrl_t              ctrl,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] reload,
    output logic               hit
);

    logic        tick;
    logic        expire;
    logic [31:0] count_word;
    logic [31:0] reload_word;
    logic [31:0] count_wr_word;
    logic [31:0] reload_wr_word;
    logic [31:0] ctrl_wr_word;

    always_comb begin
        count_word                 = '0;
        reload_word                = '0;
        count_word[COUNT_W-1:0]    = count;
        reload_word[COUNT_W-1:0]   = reload;
        count_wr_word              = merge_bytes(count_word, wdata, sel);
        reload_wr_word             = merge_bytes(reload_word, wdata, sel);
        ctrl_wr_word               = merge_bytes(ctrl_to_word(ctrl), wdata, sel);
    end

`ifdef WB_TIMER_PRESCALER_EN
    logic [7:0] psc_cnt;

    assign tick = (psc_cnt == ctrl.psc);

    // Restarting the prescaler on any CTRL write keeps the first period after reprogramming exact.
    always_ff @(posedge clk) begin
        if (rst || !ctrl.en || wr_ctrl) begin
            psc_cnt <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign expire = ctrl.en && tick && (count == '0);

    // Bus writes come after the counting updates so they win any same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl   <= '0;
            count  <= '0;
            reload <= '0;
            hit    <= 1'b0;
        end else begin
            if (ctrl.en && tick) begin
                if (count != '0) begin
                    count <= count - COUNT_W'(1);
                end else if (ctrl.auto_rl) begin
                    count <= reload;
                end else begin
                    ctrl.en <= 1'b0;
                end
            end
            if (wr_count) begin
                count <= count_wr_word[COUNT_W-1:0];
            end
            if (wr_reload) begin
                reload <= reload_wr_word[COUNT_W-1:0];
            end
            if (wr_ctrl) begin
                ctrl.en      <= ctrl_wr_word[CTRL_EN];
                ctrl.auto_rl <= ctrl_wr_word[CTRL_AUTO];
                ctrl.ie      <= ctrl_wr_word[CTRL_IE];
`ifdef WB_TIMER_PRESCALER_EN
                ctrl.psc     <= ctrl_wr_word[CTRL_PSC_LSB +: 8];
`endif
            end
            if (expire) begin
                hit <= 1'b1;
            end else if (wr_status && sel[0] && wdata[0]) begin
                hit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_timer_bank.sv
// Wishbone bank of NUM_CH down-counting timers with a combined registered interrupt.
// Define WB_TIMER_PRESCALER_EN to give each channel an 8-bit tick prescaler.
module wb_timer_bank
    import wb_timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    logic               access;
    logic               bus_we;
    logic               ch_ok;
    logic [3:0]         ch;
    logic [1:0]         off;
    logic [31:0]        rd_word;
    ctrl_t              ctrl_q   [NUM_CH];
    logic [COUNT_W-1:0] count_q  [NUM_CH];
    logic [COUNT_W-1:0] reload_q [NUM_CH];
    logic [NUM_CH-1:0]  hit_q;
    logic [NUM_CH-1:0]  irq_vec;

    // The !ack term gives one wait state and guarantees ack never stays high two cycles.
    assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign ch     = wb_adr_i[7:4];
    assign off    = wb_adr_i[3:2];
    assign ch_ok  = ({28'd0, ch} < NUM_CH);
    assign bus_we = access & wb_we_i & ch_ok;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ch_we;
        assign ch_we = bus_we && (ch == 4'(c));

        wb_timer_channel #(
            .COUNT_W (COUNT_W)
        ) u_ch (
            .clk       (wb_clk_i),
            .rst       (wb_rst_i),
            .wr_ctrl   (ch_we && (off == REG_CTRL)),
            .wr_count  (ch_we && (off == REG_COUNT)),
            .wr_reload (ch_we && (off == REG_RELOAD)),
            .wr_status (ch_we && (off == REG_STATUS)),
            .wdata     (wb_dat_i),
            .sel       (wb_sel_i),
            .ctrl      (ctrl_q[c]),
            .count     (count_q[c]),
            .reload    (reload_q[c]),
            .hit       (hit_q[c])
        );

        assign irq_vec[c] = hit_q[c] & ctrl_q[c].ie;
    end

    // Channels outside the bank fall through with rd_word left at zero.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 4'(c)) begin
                case (off)
                    REG_CTRL:   rd_word = ctrl_to_word(ctrl_q[c]);
                    REG_COUNT:  rd_word[COUNT_W-1:0] = count_q[c];
                    REG_RELOAD: rd_word[COUNT_W-1:0] = reload_q[c];
                    REG_STATUS: rd_word[0] = hit_q[c];
                    default:    rd_word = '0;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            wb_ack_o <= access;
            if (access && !wb_we_i) begin
                wb_dat_o <= rd_word;
            end
            irq_o <= |irq_vec;
        end
    end

endmodule

// File: tb/tb_wb_timer_bank.sv
// Directed self-checking bench for wb_timer_bank (NUM_CH=4, COUNT_W=16).
// Expected timing adapts to whether WB_TIMER_PRESCALER_EN is defined.
module tb_wb_timer_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic        ack;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    wb_timer_bank #(
        .NUM_CH  (4),
        .COUNT_W (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_dat_o (dat_r),
        .wb_ack_o (ack),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic goto_edge(input int n);
        while (cyc_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access: strobe raised 1ns after an edge, returns 1ns after the ack edge.
    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rdata, output int lat);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        lat = -1;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (ack) lat = i;
        end
        rdata = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (lat < 0) begin
            total++; bad++;
            $display("[TB] FAIL ack_timeout adr=%h: got no ack, expected ack within 8 cycles", a);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused_d;
        int          unused_l;
        wb_cycle(1'b1, a, d, s, unused_d, unused_l);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int unused_l;
        wb_cycle(1'b0, a, 32'h0, 4'hF, d, unused_l);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] a;
        int          lat;
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
        total++; if (dat_r !== 32'h0) begin bad++; $display("[TB] FAIL reset_dat: got %h expected 0", dat_r); end
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 4; r++) begin
                a = 32'((c == 0 ? 0 : 3) * 16 + r * 4);
                wb_cycle(1'b0, a, 32'h0, 4'hF, d, lat);
                total++;
                if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_read adr=%h: got %h expected 0", a, d); end
                total++;
                if (lat !== 1) begin bad++; $display("[TB] FAIL reset_ack_latency adr=%h: got %0d expected 1", a, lat); end
            end
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        int          e0;
        int          a;
        wb_write(32'h04, 32'd3, 4'hF);
        wb_write(32'h00, 32'h5, 4'hF);
        e0 = cyc_n;
        goto_edge(e0 + 4);
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL oneshot_irq_early: got %b expected 0", irq); end
        goto_edge(e0 + 5);
        total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL oneshot_irq_rise: got %b expected 1", irq); end
        wb_read(32'h00, d);
        total++; if (d !== 32'h4) begin bad++; $display("[TB] FAIL oneshot_ctrl: got %h expected 00000004", d); end
        wb_read(32'h04, d);
        total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL oneshot_count: got %h expected 0", d); end
        wb_read(32'h0C, d);
        total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL oneshot_hit: got %h expected 1", d); end
        wb_write(32'h0C, 32'h1, 4'hF);
        a = cyc_n;
        total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL clear_irq_hold: got %b expected 1", irq); end
        goto_edge(a + 1);
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL clear_irq_drop: got %b expected 0", irq); end
        wb_read(32'h0C, d);
        total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL clear_hit: got %h expected 0", d); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic [31:0] exp_v;
        int          e0;
        int          t;
        int          k;
        int          targets[5] = '{2, 7, 13, 24, 50};
        wb_write(32'h18, 32'd4, 4'hF);
        wb_write(32'h14, 32'd4, 4'hF);
        wb_write(32'h10, 32'h3, 4'hF);
        e0 = cyc_n;
        foreach (targets[i]) begin
            goto_edge(e0 + targets[i] - 2);
            wb_read(32'h14, d);
            k = targets[i] - 1;
            exp_v = 32'(((4 - k) % 5 + 5) % 5);
            total++;
            if (d !== exp_v) begin bad++; $display("[TB] FAIL auto_count t=%0d: got %h expected %h", targets[i], d, exp_v); end
        end
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL auto_irq_masked: got %b expected 0", irq); end
        wb_read(32'h1C, d);
        total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL auto_hit: got %h expected 1", d); end
        t = cyc_n + 2;
        while ((t - e0) % 5 != 2) t++;
        goto_edge(t - 2);
        wb_write(32'h1C, 32'h1, 4'hF);
        wb_read(32'h1C, d);
        total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL auto_w1c: got %h expected 0", d); end
        t = cyc_n + 2;
        while ((t - e0) % 5 != 0) t++;
        goto_edge(t - 2);
        wb_write(32'h1C, 32'h1, 4'hF);
        wb_read(32'h1C, d);
        total++; if (d !== 32'h1) begin bad++; $display("[TB] FAIL auto_w1c_vs_hit: got %h expected 1", d); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] d;
        int          lat;
        wb_write(32'h08, 32'hDEADBEEF, 4'b0001);
        wb_read(32'h08, d);
        total++; if (d !== 32'h000000EF) begin bad++; $display("[TB] FAIL sel_reload_b0: got %h expected 000000EF", d); end
        wb_write(32'h08, 32'h12345678, 4'b0100);
        wb_read(32'h08, d);
        total++; if (d !== 32'h000000EF) begin bad++; $display("[TB] FAIL sel_reload_b2: got %h expected 000000EF", d); end
        wb_write(32'h04, 32'hDEADBEEF, 4'hF);
        wb_read(32'h04, d);
        total++; if (d !== 32'h0000BEEF) begin bad++; $display("[TB] FAIL count_trunc: got %h expected 0000BEEF", d); end
        wb_write(32'h04, 32'h0000AA00, 4'b0010);
        wb_read(32'h04, d);
        total++; if (d !== 32'h0000AAEF) begin bad++; $display("[TB] FAIL sel_count_b1: got %h expected 0000AAEF", d); end
        wb_cycle(1'b1, 32'hF8, 32'h77, 4'hF, d, lat);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL bad_ch_write_ack: got %0d expected 1", lat); end
        wb_cycle(1'b0, 32'hF8, 32'h0, 4'hF, d, lat);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL bad_ch_read_ack: got %0d expected 1", lat); end
        total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL bad_ch_read: got %h expected 0", d); end
        wb_read(32'h38, d);
        total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL bad_ch_alias: got %h expected 0", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        int          e0;
        int          t;
        wb_write(32'h28, 32'd4, 4'hF);
        wb_write(32'h24, 32'd4, 4'hF);
        wb_write(32'h20, 32'h3, 4'hF);
        e0 = cyc_n;
        goto_edge(e0 + 8);
        wb_write(32'h24, 32'd100, 4'hF);
        t = cyc_n;
        total++; if (t !== e0 + 10) begin bad++; $display("[TB] FAIL coll_ack_edge: got %0d expected %0d", t, e0 + 10); end
        wb_read(32'h24, d);
        total++; if (d !== 32'd99) begin bad++; $display("[TB] FAIL coll_count_1: got %0d expected 99", d); end
        goto_edge(t + 8);
        wb_read(32'h24, d);
        total++; if (d !== 32'd91) begin bad++; $display("[TB] FAIL coll_count_2: got %0d expected 91", d); end
        wb_write(32'h34, 32'd1, 4'hF);
        wb_write(32'h30, 32'h1, 4'hF);
        e0 = cyc_n;
        wb_write(32'h30, 32'h3, 4'hF);
        total++; if (cyc_n !== e0 + 2) begin bad++; $display("[TB] FAIL en_coll_ack_edge: got %0d expected %0d", cyc_n, e0 + 2); end
        wb_read(32'h30, d);
        total++; if (d !== 32'h3) begin bad++; $display("[TB] FAIL en_coll_ctrl: got %h expected 00000003", d); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        logic [31:0] exp_ctrl;
        int          e0;
        int          irq_edge;
`ifdef WB_TIMER_PRESCALER_EN
        irq_edge = 13;
        exp_ctrl = 32'h00000304;
`else
        irq_edge = 4;
        exp_ctrl = 32'h00000004;
`endif
        wb_write(32'h04, 32'd2, 4'hF);
        wb_write(32'h00, 32'h0305, 4'hF);
        e0 = cyc_n;
        goto_edge(e0 + irq_edge - 1);
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL psc_irq_early: got %b expected 0", irq); end
        goto_edge(e0 + irq_edge);
        total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL psc_irq_rise: got %b expected 1", irq); end
        wb_read(32'h00, d);
        total++; if (d !== exp_ctrl) begin bad++; $display("[TB] FAIL psc_ctrl: got %h expected %h", d, exp_ctrl); end
    endtask

    initial begin
        $display("[TB] starting wb_timer_bank bench");
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_byte_enables();
        test_collision();
        test_prescaler();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
